// File: rtl/mesi_tag_array_assoc_if.sv
// Bus bundle for the set-associative MESI tag array: processor lookup,
// processor write and snoop ports plus their registered responses.
interface mesi_tag_array_assoc_if #(
   parameter int INDEX_W = 10,
   parameter int TAG_W   = 20,
   parameter int WAYS    = 4,
   parameter int WAY_W   = $clog2(WAYS)
);
   logic               init_done;

   // Valid-only handshake: a request is taken on any rising edge where its
   // valid is high and init_done is high; there is no ready. Each response
   // valid pulses for exactly one cycle, one cycle after the taken request.
   logic               req_valid;
   logic [INDEX_W-1:0] req_index;
   logic [TAG_W-1:0]   req_tag;
   logic               rsp_valid;
   logic               rsp_hit;
   logic [WAY_W-1:0]   rsp_way;
   logic [1:0]         rsp_state;

   logic               wr_en;
   logic [INDEX_W-1:0] wr_index;
   logic [WAY_W-1:0]   wr_way;
   logic [TAG_W-1:0]   wr_tag;
   logic [1:0]         wr_state;

   logic               snp_valid;
   logic [INDEX_W-1:0] snp_index;
   logic [TAG_W-1:0]   snp_tag;
   logic               snp_inv;
   logic               snp_rsp_valid;
   logic               snp_hit;
   logic [1:0]         snp_state;
   logic               snp_dirty;

   modport master (
      input  init_done,
      output req_valid, req_index, req_tag,
      input  rsp_valid, rsp_hit, rsp_way, rsp_state,
      output wr_en, wr_index, wr_way, wr_tag, wr_state,
      output snp_valid, snp_index, snp_tag, snp_inv,
      input  snp_rsp_valid, snp_hit, snp_state, snp_dirty
   );

   modport slave (
      output init_done,
      input  req_valid, req_index, req_tag,
      output rsp_valid, rsp_hit, rsp_way, rsp_state,
      input  wr_en, wr_index, wr_way, wr_tag, wr_state,
      input  snp_valid, snp_index, snp_tag, snp_inv,
      output snp_rsp_valid, snp_hit, snp_state, snp_dirty
   );
endinterface

// File: rtl/mesi_tag_array_assoc.sv
// N-way set-associative MESI tag array with registered lookup, fill port,
// single-cycle snoop read-modify-write and a post-reset invalidate sweep.
module mesi_tag_array_assoc #(
   parameter  int INDEX_W = 10,
   parameter  int TAG_W   = 20,
   parameter  int WAYS    = 4,
   localparam int WAY_W   = $clog2(WAYS)
) (
   input logic                 clk,
   input logic                 rst_n,
   mesi_tag_array_assoc_if.slave bus
);
   localparam int SETS = 1 << INDEX_W;
   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b11;

   logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
   logic [1:0]         state_q [SETS][WAYS];
   logic [WAY_W-1:0]   ptr_q   [SETS];

   logic [INDEX_W-1:0] sweep_q, sweep_d;
   logic               init_done_q, init_done_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_hit_q, rsp_hit_d;
   logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;
   logic [1:0]         rsp_state_q, rsp_state_d;
   logic               snp_rsp_valid_q, snp_rsp_valid_d;
   logic               snp_hit_q, snp_hit_d;
   logic [1:0]         snp_state_q, snp_state_d;
   logic               snp_dirty_q, snp_dirty_d;

   logic               req_fire, wr_fire, snp_fire;
   logic               lk_hit, lk_free;
   logic [WAY_W-1:0]   lk_way, lk_free_way;
   logic [1:0]         lk_state;
   logic               sn_hit;
   logic [WAY_W-1:0]   sn_way;
   logic [1:0]         sn_old, sn_new;
   logic [1:0]         wr_old, wr_state_eff;
   logic               ptr_adv;

   always_comb begin
      req_fire = init_done_q & bus.req_valid;
      wr_fire  = init_done_q & bus.wr_en;
      snp_fire = init_done_q & bus.snp_valid;

      // Downward scans leave the lowest-numbered qualifying way selected.
      lk_hit      = 1'b0;
      lk_way      = '0;
      lk_state    = ST_I;
      lk_free     = 1'b0;
      lk_free_way = '0;
      sn_hit      = 1'b0;
      sn_way      = '0;
      sn_old      = ST_I;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (state_q[bus.req_index][w] != ST_I && tag_q[bus.req_index][w] == bus.req_tag) begin
            lk_hit   = 1'b1;
            lk_way   = WAY_W'(w);
            lk_state = state_q[bus.req_index][w];
         end
         if (state_q[bus.req_index][w] == ST_I) begin
            lk_free     = 1'b1;
            lk_free_way = WAY_W'(w);
         end
         if (state_q[bus.snp_index][w] != ST_I && tag_q[bus.snp_index][w] == bus.snp_tag) begin
            sn_hit = snp_fire;
            sn_way = WAY_W'(w);
            sn_old = state_q[bus.snp_index][w];
         end
      end
      sn_new = bus.snp_inv ? ST_I : ST_S;

      // A snoop hitting the way being written keeps the coherence outcome.
      wr_old       = state_q[bus.wr_index][bus.wr_way];
      ptr_adv      = wr_fire && wr_old != ST_I && bus.wr_state != ST_I;
      wr_state_eff = (sn_hit && bus.snp_index == bus.wr_index && sn_way == bus.wr_way)
                     ? sn_new : bus.wr_state;

      sweep_d     = sweep_q;
      init_done_d = init_done_q;
      if (!init_done_q) begin
         sweep_d = sweep_q + INDEX_W'(1);
         if (sweep_q == INDEX_W'(SETS - 1)) init_done_d = 1'b1;
      end

      rsp_valid_d     = req_fire;
      rsp_hit_d       = req_fire & lk_hit;
      rsp_way_d       = lk_hit ? lk_way : (lk_free ? lk_free_way : ptr_q[bus.req_index]);
      rsp_state_d     = lk_hit ? lk_state : ST_I;
      snp_rsp_valid_d = snp_fire;
      snp_hit_d       = sn_hit;
      snp_state_d     = sn_hit ? sn_old : ST_I;
      snp_dirty_d     = sn_hit && sn_old == ST_M;
   end

   // Storage is not reset; the sweep clears one set per cycle instead.
   always_ff @(posedge clk) begin
      if (!init_done_q) begin
         for (int w = 0; w < WAYS; w++) begin
            tag_q[sweep_q][w]   <= '0;
            state_q[sweep_q][w] <= ST_I;
         end
         ptr_q[sweep_q] <= '0;
      end else begin
         if (sn_hit) state_q[bus.snp_index][sn_way] <= sn_new;
         if (wr_fire) begin
            tag_q[bus.wr_index][bus.wr_way]   <= bus.wr_tag;
            state_q[bus.wr_index][bus.wr_way] <= wr_state_eff;
         end
         if (ptr_adv) ptr_q[bus.wr_index] <= bus.wr_way + WAY_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_q         <= '0;
         init_done_q     <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_hit_q       <= 1'b0;
         rsp_way_q       <= '0;
         rsp_state_q     <= ST_I;
         snp_rsp_valid_q <= 1'b0;
         snp_hit_q       <= 1'b0;
         snp_state_q     <= ST_I;
         snp_dirty_q     <= 1'b0;
      end else begin
         sweep_q         <= sweep_d;
         init_done_q     <= init_done_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_hit_q       <= rsp_hit_d;
         rsp_way_q       <= rsp_way_d;
         rsp_state_q     <= rsp_state_d;
         snp_rsp_valid_q <= snp_rsp_valid_d;
         snp_hit_q       <= snp_hit_d;
         snp_state_q     <= snp_state_d;
         snp_dirty_q     <= snp_dirty_d;
      end
   end

   assign bus.init_done     = init_done_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_hit       = rsp_hit_q;
   assign bus.rsp_way       = rsp_way_q;
   assign bus.rsp_state     = rsp_state_q;
   assign bus.snp_rsp_valid = snp_rsp_valid_q;
   assign bus.snp_hit       = snp_hit_q;
   assign bus.snp_state     = snp_state_q;
   assign bus.snp_dirty     = snp_dirty_q;
endmodule

// File: tb/tb_mesi_tag_array_assoc.sv
// Bench for mesi_tag_array_assoc: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_mesi_tag_array_assoc;
   localparam int INDEX_W = 10;
   localparam int TAG_W   = 20;
   localparam int WAYS    = 4;
   localparam int WAY_W   = $clog2(WAYS);
   localparam int SETS    = 1 << INDEX_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mesi_tag_array_assoc_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .WAYS(WAYS), .WAY_W(WAY_W)) bus_if ();

   mesi_tag_array_assoc #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .WAYS(WAYS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: plain arrays of lines, updated once per clock edge.
   logic [TAG_W-1:0] mtag [SETS][WAYS];
   logic [1:0]       mst  [SETS][WAYS];
   int               mptr [SETS];
   int               m_cnt;
   logic             m_init;
   logic             e_init, e_rsp_valid, e_rsp_hit, e_snp_valid, e_snp_hit, e_snp_dirty;
   logic [WAY_W-1:0] e_rsp_way;
   logic [1:0]       e_rsp_state, e_snp_state;

   function automatic int find_match(input int idx, input logic [TAG_W-1:0] t, output int n);
      int first = -1;
      n = 0;
      for (int w = 0; w < WAYS; w++)
         if (mst[idx][w] != 2'b00 && mtag[idx][w] == t) begin
            n++;
            if (first < 0) first = w;
         end
      return first;
   endfunction

   function automatic int victim(input int idx);
      for (int w = 0; w < WAYS; w++)
         if (mst[idx][w] == 2'b00) return w;
      return mptr[idx];
   endfunction

   int   lw, ln, sw, sn, wi, ww;
   logic [1:0] sold, snew, wold;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_init = 1'b0; m_cnt = 0; e_init = 1'b0;
         e_rsp_valid = 1'b0; e_rsp_hit = 1'b0; e_rsp_way = '0; e_rsp_state = 2'b00;
         e_snp_valid = 1'b0; e_snp_hit = 1'b0; e_snp_state = 2'b00; e_snp_dirty = 1'b0;
         for (int s = 0; s < SETS; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
               mtag[s][w] = '0;
               mst[s][w]  = 2'b00;
            end
         end
      end else if (!m_init) begin
         m_cnt++;
         e_rsp_valid = 1'b0;
         e_snp_valid = 1'b0;
         if (m_cnt == SETS) m_init = 1'b1;
         e_init = m_init;
      end else begin
         e_rsp_valid = bus_if.req_valid;
         if (bus_if.req_valid) begin
            lw = find_match(int'(bus_if.req_index), bus_if.req_tag, ln);
            chk("multi_match_req", 32'(ln > 1), 32'd0);
            e_rsp_hit   = (lw >= 0);
            e_rsp_way   = WAY_W'((lw >= 0) ? lw : victim(int'(bus_if.req_index)));
            e_rsp_state = (lw >= 0) ? mst[bus_if.req_index][lw] : 2'b00;
         end
         e_snp_valid = bus_if.snp_valid;
         sw = -1;
         snew = bus_if.snp_inv ? 2'b00 : 2'b01;
         if (bus_if.snp_valid) begin
            sw = find_match(int'(bus_if.snp_index), bus_if.snp_tag, sn);
            sold = (sw >= 0) ? mst[bus_if.snp_index][sw] : 2'b00;
            e_snp_hit   = (sw >= 0);
            e_snp_state = sold;
            e_snp_dirty = (sold == 2'b11);
         end
         wi = int'(bus_if.wr_index);
         ww = int'(bus_if.wr_way);
         wold = mst[wi][ww];
         if (sw >= 0) mst[bus_if.snp_index][sw] = snew;
         if (bus_if.wr_en) begin
            mtag[wi][ww] = bus_if.wr_tag;
            if (sw >= 0 && int'(bus_if.snp_index) == wi && sw == ww) mst[wi][ww] = snew;
            else mst[wi][ww] = bus_if.wr_state;
            if (wold != 2'b00 && bus_if.wr_state != 2'b00) mptr[wi] = (ww + 1) % WAYS;
         end
         e_init = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("init_done", 32'(bus_if.init_done), 32'(e_init));
      chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(e_rsp_valid));
      if (e_rsp_valid) begin
         chk("rsp_hit", 32'(bus_if.rsp_hit), 32'(e_rsp_hit));
         chk("rsp_way", 32'(bus_if.rsp_way), 32'(e_rsp_way));
         chk("rsp_state", 32'(bus_if.rsp_state), 32'(e_rsp_state));
      end
      chk("snp_rsp_valid", 32'(bus_if.snp_rsp_valid), 32'(e_snp_valid));
      if (e_snp_valid) begin
         chk("snp_hit", 32'(bus_if.snp_hit), 32'(e_snp_hit));
         chk("snp_state", 32'(bus_if.snp_state), 32'(e_snp_state));
         chk("snp_dirty", 32'(bus_if.snp_dirty), 32'(e_snp_dirty));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus_if.req_valid = 1'b0; bus_if.req_index = '0; bus_if.req_tag = '0;
      bus_if.wr_en = 1'b0; bus_if.wr_index = '0; bus_if.wr_way = '0;
      bus_if.wr_tag = '0; bus_if.wr_state = 2'b00;
      bus_if.snp_valid = 1'b0; bus_if.snp_index = '0; bus_if.snp_tag = '0; bus_if.snp_inv = 1'b0;
   endtask

   // Counts edges from reset release; a lookup is offered on the last
   // edge before init_done and must be ignored.
   task automatic init_check(input string tag);
      for (int k = 1; k < SETS; k++) tick;
      chk({tag, "_init_early"}, 32'(bus_if.init_done), 32'd0);
      bus_if.req_valid = 1'b1;
      tick;
      bus_if.req_valid = 1'b0;
      chk({tag, "_init_at_sets"}, 32'(bus_if.init_done), 32'd1);
      chk({tag, "_no_rsp_pre_init"}, 32'(bus_if.rsp_valid), 32'd0);
   endtask

   task automatic do_write(input int idx, input int way, input logic [TAG_W-1:0] t, input logic [1:0] st);
      bus_if.wr_en = 1'b1; bus_if.wr_index = INDEX_W'(idx); bus_if.wr_way = WAY_W'(way);
      bus_if.wr_tag = t; bus_if.wr_state = st;
      tick;
      bus_if.wr_en = 1'b0;
   endtask

   task automatic do_lookup(input int idx, input logic [TAG_W-1:0] t);
      bus_if.req_valid = 1'b1; bus_if.req_index = INDEX_W'(idx); bus_if.req_tag = t;
      tick;
      bus_if.req_valid = 1'b0;
   endtask

   task automatic do_snoop(input int idx, input logic [TAG_W-1:0] t, input logic inv);
      bus_if.snp_valid = 1'b1; bus_if.snp_index = INDEX_W'(idx); bus_if.snp_tag = t; bus_if.snp_inv = inv;
      tick;
      bus_if.snp_valid = 1'b0;
   endtask

   function automatic logic [INDEX_W-1:0] rand_idx();
      if ($urandom_range(0, 7) == 0) return INDEX_W'($urandom_range(0, SETS - 1));
      return INDEX_W'($urandom_range(0, 3));
   endfunction

   task automatic random_cycle;
      bus_if.req_valid = 1'($urandom_range(0, 1));
      bus_if.req_index = rand_idx();
      bus_if.req_tag   = TAG_W'($urandom_range(0, 5));
      bus_if.wr_en     = ($urandom_range(0, 2) == 0);
      bus_if.wr_index  = rand_idx();
      bus_if.wr_way    = WAY_W'($urandom_range(0, WAYS - 1));
      bus_if.wr_tag    = TAG_W'($urandom_range(0, 5));
      bus_if.wr_state  = 2'($urandom_range(0, 3));
      // Redirect a fill onto the way already holding its tag so no set
      // ever gains two live copies of one tag.
      for (int w = 0; w < WAYS; w++)
         if (mst[bus_if.wr_index][w] != 2'b00 && mtag[bus_if.wr_index][w] == bus_if.wr_tag)
            bus_if.wr_way = WAY_W'(w);
      bus_if.snp_valid = ($urandom_range(0, 2) == 0);
      bus_if.snp_index = ($urandom_range(0, 3) == 0) ? bus_if.wr_index : rand_idx();
      bus_if.snp_tag   = TAG_W'($urandom_range(0, 5));
      bus_if.snp_inv   = 1'($urandom_range(0, 1));
      tick;
   endtask

   localparam logic [TAG_W-1:0] T_A = 20'hABCDE;
   localparam logic [TAG_W-1:0] T_T = 20'h33333;

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) tick;
      chk("reset_init_done", 32'(bus_if.init_done), 32'd0);
      chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("reset_snp_rsp_valid", 32'(bus_if.snp_rsp_valid), 32'd0);
      rst_n = 1'b1;
      init_check("first");

      do_write(5, 2, T_A, 2'b10);
      do_lookup(5, T_A);
      chk("set5_hit", 32'(bus_if.rsp_hit), 32'd1);
      chk("set5_way", 32'(bus_if.rsp_way), 32'd2);
      chk("set5_state", 32'(bus_if.rsp_state), 32'd2);
      do_lookup(5, 20'h12345);
      chk("set5_miss_hit", 32'(bus_if.rsp_hit), 32'd0);
      chk("set5_miss_way", 32'(bus_if.rsp_way), 32'd0);
      chk("set5_miss_state", 32'(bus_if.rsp_state), 32'd0);

      for (int w = 0; w < WAYS; w++) do_write(7, w, TAG_W'(32'h70000 + w), 2'b01);
      do_write(7, 1, 20'h7AAAA, 2'b10);
      do_lookup(7, 20'h7FFFF);
      chk("set7_rr_hit", 32'(bus_if.rsp_hit), 32'd0);
      chk("set7_rr_way", 32'(bus_if.rsp_way), 32'd2);

      do_write(9, 3, 20'h00042, 2'b11);
      do_snoop(9, 20'h00042, 1'b0);
      chk("snp_rd_hit", 32'(bus_if.snp_hit), 32'd1);
      chk("snp_rd_state", 32'(bus_if.snp_state), 32'd3);
      chk("snp_rd_dirty", 32'(bus_if.snp_dirty), 32'd1);
      do_lookup(9, 20'h00042);
      chk("set9_after_rd_hit", 32'(bus_if.rsp_hit), 32'd1);
      chk("set9_after_rd_way", 32'(bus_if.rsp_way), 32'd3);
      chk("set9_after_rd_state", 32'(bus_if.rsp_state), 32'd1);
      do_snoop(9, 20'h00042, 1'b1);
      chk("snp_inv_hit", 32'(bus_if.snp_hit), 32'd1);
      chk("snp_inv_state", 32'(bus_if.snp_state), 32'd1);
      chk("snp_inv_dirty", 32'(bus_if.snp_dirty), 32'd0);
      do_lookup(9, 20'h00042);
      chk("set9_after_inv_hit", 32'(bus_if.rsp_hit), 32'd0);
      chk("set9_after_inv_state", 32'(bus_if.rsp_state), 32'd0);

      do_write(3, 0, T_T, 2'b01);
      bus_if.wr_en = 1'b1; bus_if.wr_index = 10'd3; bus_if.wr_way = 2'd0;
      bus_if.wr_tag = T_T; bus_if.wr_state = 2'b11;
      bus_if.snp_valid = 1'b1; bus_if.snp_index = 10'd3; bus_if.snp_tag = T_T; bus_if.snp_inv = 1'b1;
      tick;
      idle_inputs();
      chk("same_cyc_snp_hit", 32'(bus_if.snp_hit), 32'd1);
      chk("same_cyc_snp_state", 32'(bus_if.snp_state), 32'd1);
      do_lookup(3, T_T);
      chk("same_cyc_after_hit", 32'(bus_if.rsp_hit), 32'd0);
      chk("same_cyc_after_way", 32'(bus_if.rsp_way), 32'd0);

      for (int c = 0; c < 3000; c++) random_cycle();
      idle_inputs();
      tick;

      do_write(5, 2, T_A, 2'b10);
      do_lookup(5, T_A);
      chk("pre_reset_hit", 32'(bus_if.rsp_hit), 32'd1);
      rst_n = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      repeat (300) tick;
      chk("mid_sweep_init", 32'(bus_if.init_done), 32'd0);
      rst_n = 1'b0;
      tick;
      chk("mid_sweep_reset_init", 32'(bus_if.init_done), 32'd0);
      rst_n = 1'b1;
      init_check("second");
      do_lookup(5, T_A);
      chk("post_reset_miss_hit", 32'(bus_if.rsp_hit), 32'd0);
      chk("post_reset_miss_way", 32'(bus_if.rsp_way), 32'd0);
      chk("post_reset_miss_state", 32'(bus_if.rsp_state), 32'd0);
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mesi_tag_array_assoc.md
Name: mesi_tag_array_assoc

Overview:
- Parametrised, N-way set-associative successor to the direct-mapped MESI tag array.
- Stores a tag and a 2-bit MESI state per way, per set.
- Provides:
  - a registered processor lookup with hit-way and victim selection;
  - a processor fill/update write port;
  - a snoop port that compares and downgrades/invalidates in a single read-modify-write cycle.
- Sits between the L1 cache controller and the bus snoop logic. After any reset it self-initialises by sweeping every set to Invalid.

Parameters:
- INDEX_W, 10, set index width; SETS = 2**INDEX_W.
- TAG_W, 20, address tag width.
- WAYS, 4, associativity (power of 2, >= 2).
- WAY_W, $clog2(WAYS), way-number width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the post-reset invalidate sweep completes.
- req_valid  in  1  processor lookup request.
- req_index  in  INDEX_W  lookup set.
- req_tag  in  TAG_W  lookup tag.
- rsp_valid  out  1  lookup result valid (one cycle after an accepted req).
- rsp_hit  out  1  tag match in a non-I way.
- rsp_way  out  WAY_W  hitting way if hit, else victim way.
- rsp_state  out  2  state of hitting way; 00 on miss.
- wr_en  in  1  write one way.
- wr_index  in  INDEX_W  write set.
- wr_way  in  WAY_W  write way.
- wr_tag  in  TAG_W  tag to store.
- wr_state  in  2  MESI state to store.
- snp_valid  in  1  snoop request.
- snp_index  in  INDEX_W  snoop set.
- snp_tag  in  TAG_W  snoop tag.
- snp_inv  in  1  1 = invalidate on hit (BusRdX/BusUpgr); 0 = downgrade to S (BusRd).
- snp_rsp_valid  out  1  snoop result valid, one cycle after request.
- snp_hit  out  1  snoop matched a non-I way.
- snp_state  out  2  pre-snoop state of the matched way; 00 on miss.
- snp_dirty  out  1  matched way was M (owner must supply data).

Behaviour:
- State encoding: I=00, S=01, E=10, M=11. A way matches only if its state != I and the stored tag equals the request tag.
- Reset (rst_n low, asynchronous): all output registers clear to 0 and init_done=0. The sweep counter is held at 0.
- Init sweep:
  - Starts on the first clk edge after rst_n rises.
  - Each cycle writes one set: all ways get state I, tag 0, and the victim pointer is cleared to 0.
  - After SETS cycles, init_done=1 and stays high until the next reset.
  - Reset asserted mid-sweep restarts the sweep from set 0.
  - While init_done=0, req_valid, wr_en and snp_valid are ignored: no response, no update.
- Lookup:
  - Array read is combinational; results register on the next edge, giving latency 1 with no back-pressure. Every cycle may carry a request.
  - Hit: rsp_hit=1, rsp_way = matching way, rsp_state = its state.
  - Miss: rsp_hit=0, rsp_state=00, rsp_way = victim:
    - lowest-numbered way in state I;
    - if no way is I, the set's round-robin pointer.
  - Multiple matching ways is illegal. The lowest way wins, and the bench asserts this never occurs.
- Write: on an edge with wr_en=1, {wr_state, wr_tag} is stored into [wr_index][wr_way].
  - If the way being overwritten was non-I and wr_state != I (a replacement fill), the set's pointer advances to (wr_way+1) mod WAYS.
  - Otherwise the pointer is unchanged.
- Snoop:
  - Compare uses pre-edge contents. Response registers next edge: snp_hit, snp_state = old state, snp_dirty = (old state == M).
  - On hit, the same edge writes the state: I if snp_inv=1, else S if the old state was E or M; S stays S.
  - Tag is untouched.
- Same-cycle interactions:
  - Lookup concurrent with a write or snoop update to the same set returns pre-edge contents (read-before-write).
  - wr_en and snp_valid on the same set: snoop compares pre-edge contents. If the snoop hits wr_way, the snoop-derived state overrides wr_state while the tag comes from wr_tag. Otherwise both updates apply.
- rsp_valid and snp_rsp_valid are single-cycle pulses that mirror the accepted request one cycle earlier.

Test Plan:
- Reset, then idle: init_done rises exactly SETS cycles after rst_n deasserts (1024 with defaults). A req issued one cycle earlier produces no rsp_valid.
- Fill set 5 way 2 with tag 0xABCDE state E, then lookup (5, 0xABCDE) -> next cycle rsp_hit=1, rsp_way=2, rsp_state=10. Lookup tag 0x12345 -> rsp_hit=0, rsp_way=0 (first I way).
- Fill all 4 ways of set 7 (states non-I), then fill way 1 over a valid line -> pointer=2. A miss lookup on set 7 -> rsp_way=2.
- Set 9 way 3 holds tag 0x00042 state M; snoop (9, 0x00042, inv=0) -> snp_hit=1, snp_state=11, snp_dirty=1. A following lookup returns state 01. A second snoop with inv=1 -> snp_state=01, snp_dirty=0, and the line becomes I.
- Same cycle: wr_en (set 3, way 0, tag T, state M) with snp_valid (set 3, tag T, inv=1) where way 0 held tag T state S -> snp_hit=1, snp_state=01. Afterwards way 0 holds tag T state I.
- Pulse rst_n low 300 cycles into the sweep: init_done stays 0, the sweep restarts, and init_done rises SETS cycles after the second deassertion. Lines written before the reset read back as misses.
